rco_capture_fifo: RTL and testbench

- Downstream consumer of the 32-bit counter (contador).
- On every cycle where the counter's ripple-carry output RCO is high, snapshots Q into a small FIFO.
- Presents buffered snapshots to a downstream reader over a valid/ready handshake.
- Tracks total and dropped rollover events so the checker and a future reporting stage can audit counter wrap behaviour.

---
 rtl/rco_capture_fifo_pkg.sv | 7 +
 rtl/rco_capture_fifo_if.sv | 30 +++
 rtl/rco_capture_fifo_sync_fifo_core.sv | 39 +++
 rtl/rco_capture_fifo.sv | 52 +++++
 tb/tb_rco_capture_fifo.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/rco_capture_fifo_pkg.sv
// rco_capture_fifo_pkg: shared default sizes and timestamp width for the RCO capture FIFO
package rco_capture_fifo_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam int TS_W = 16;
endpackage

// File: rtl/rco_capture_fifo_if.sv
// rco_capture_fifo_if: capture inputs, valid/ready read port and audit counters of rco_capture_fifo
interface rco_capture_fifo_if
    import rco_capture_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic             CAP_EN;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             CLR;
    logic [WIDTH-1:0] DATA_OUT;
    logic             VALID;
    logic             READY;
    logic [LW-1:0]    LEVEL;
    logic [CNT_W-1:0] RCO_TOTAL;
    logic [CNT_W-1:0] DROP_CNT;
    logic             OVF;
    logic [TS_W-1:0]  TS_OUT;
    modport master (
        output CAP_EN, Q, RCO, CLR, READY,
        input  DATA_OUT, VALID, LEVEL, RCO_TOTAL, DROP_CNT, OVF, TS_OUT
    );
    modport slave (
        input  CAP_EN, Q, RCO, CLR, READY,
        output DATA_OUT, VALID, LEVEL, RCO_TOTAL, DROP_CNT, OVF, TS_OUT
    );
endinterface

// File: rtl/rco_capture_fifo_sync_fifo_core.sv
// sync_fifo_core: power-of-two synchronous FIFO; extra pointer MSB separates full from empty
module sync_fifo_core #(
    parameter int W = 32,
    parameter int D = 4,
    localparam int AW = $clog2(D)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);
    logic [W-1:0] mem [D];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign level = wp - rp;
    assign do_pop = pop & ~empty;
    // a pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign dout = empty ? '0 : mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(do_push);
            rp <= rp + (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rco_capture_fifo.sv
// rco_capture_fifo: snapshots Q on CAP_EN&RCO into a FIFO, counts events/drops; RCO_CAPTURE_TS_EN adds head timestamps
module rco_capture_fifo
    import rco_capture_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic RESET,
    rco_capture_fifo_if.slave bus
);
    logic ev, pop, full, empty, drop;
    assign ev = bus.CAP_EN & bus.RCO;
    assign bus.VALID = ~empty;
    assign pop = bus.VALID & bus.READY;
    assign drop = ev & full & ~pop;
`ifdef RCO_CAPTURE_TS_EN
    localparam int FW = WIDTH + TS_W;
    logic [TS_W-1:0] ts;
    logic [FW-1:0] dout;
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) ts <= '0;
        else ts <= ts + 1'b1;
    end
    sync_fifo_core #(.W(FW), .D(DEPTH)) u_core (
        .clk(clk), .rst(RESET), .push(ev), .pop(pop), .din({ts, bus.Q}),
        .dout(dout), .full(full), .empty(empty), .level(bus.LEVEL)
    );
    assign bus.DATA_OUT = dout[WIDTH-1:0];
    assign bus.TS_OUT = dout[FW-1:WIDTH];
`else
    sync_fifo_core #(.W(WIDTH), .D(DEPTH)) u_core (
        .clk(clk), .rst(RESET), .push(ev), .pop(pop), .din(bus.Q),
        .dout(bus.DATA_OUT), .full(full), .empty(empty), .level(bus.LEVEL)
    );
    assign bus.TS_OUT = '0;
`endif
    // CLR wins first, then a same-cycle event is applied on top of the cleared value
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            bus.RCO_TOTAL <= '0;
            bus.DROP_CNT <= '0;
            bus.OVF <= 1'b0;
        end else begin
            bus.RCO_TOTAL <= (bus.CLR ? '0 : bus.RCO_TOTAL) + CNT_W'(ev);
            bus.DROP_CNT <= bus.CLR ? CNT_W'(drop) :
                            (drop && bus.DROP_CNT != '1) ? bus.DROP_CNT + 1'b1 : bus.DROP_CNT;
            bus.OVF <= (bus.CLR ? 1'b0 : bus.OVF) | drop;
        end
    end
endmodule

// File: tb/tb_rco_capture_fifo.sv
// tb_rco_capture_fifo: directed checks of capture, overflow, full push/pop, gating, CLR and reset
module tb_rco_capture_fifo;
    logic clk = 1'b0;
    logic RESET = 1'b1;
    int checks = 0;
    int errors = 0;
    rco_capture_fifo_if bus ();
    rco_capture_fifo dut (.clk(clk), .RESET(RESET), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.CAP_EN = 1'b0;
        bus.Q = '0;
        bus.RCO = 1'b0;
        bus.CLR = 1'b0;
        bus.READY = 1'b0;
        #2;
        check("rst_valid", bus.VALID, 0);
        check("rst_level", bus.LEVEL, 0);
        check("rst_data", bus.DATA_OUT, 0);
        check("rst_total", bus.RCO_TOTAL, 0);
        check("rst_drop", bus.DROP_CNT, 0);
        check("rst_ovf", bus.OVF, 0);
        check("rst_ts", bus.TS_OUT, 0);
        #5 RESET = 1'b0;
        tick;
        bus.CAP_EN = 1'b1;
        bus.Q = 32'hFFFF_FFFF;
        bus.RCO = 1'b1;
        tick;
        bus.RCO = 1'b0;
        check("single_valid", bus.VALID, 1);
        check("single_data", bus.DATA_OUT, 64'hFFFF_FFFF);
        check("single_level", bus.LEVEL, 1);
        check("single_total", bus.RCO_TOTAL, 1);
        bus.READY = 1'b1;
        tick;
        bus.READY = 1'b0;
        check("single_pop_valid", bus.VALID, 0);
        check("single_pop_level", bus.LEVEL, 0);
        bus.Q = 32'hA;
        bus.RCO = 1'b1;
        tick;
        bus.Q = 32'hB;
        tick;
        bus.RCO = 1'b0;
        check("mid_level2", bus.LEVEL, 2);
        #3 RESET = 1'b1;
        #1;
        check("mid_rst_valid", bus.VALID, 0);
        check("mid_rst_level", bus.LEVEL, 0);
        check("mid_rst_total", bus.RCO_TOTAL, 0);
        check("mid_rst_data", bus.DATA_OUT, 0);
        RESET = 1'b0;
        tick;
        check("post_rst_valid", bus.VALID, 0);
        check("post_rst_data", bus.DATA_OUT, 0);
        for (int i = 1; i <= 6; i++) begin
            bus.Q = 32'(i);
            bus.RCO = 1'b1;
            tick;
        end
        bus.RCO = 1'b0;
        check("ovf_level", bus.LEVEL, 4);
        check("ovf_drop", bus.DROP_CNT, 2);
        check("ovf_flag", bus.OVF, 1);
        check("ovf_total", bus.RCO_TOTAL, 6);
        tick;
        check("ovf_hold_data", bus.DATA_OUT, 1);
        bus.READY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain", bus.DATA_OUT, 64'(i));
            tick;
        end
        bus.READY = 1'b0;
        check("ovf_empty", bus.VALID, 0);
        for (int i = 1; i <= 4; i++) begin
            bus.Q = 32'(i);
            bus.RCO = 1'b1;
            tick;
        end
        bus.Q = 32'd9;
        bus.READY = 1'b1;
        tick;
        bus.RCO = 1'b0;
        check("full_pp_level", bus.LEVEL, 4);
        check("full_pp_drop", bus.DROP_CNT, 2);
        check("full_pp_total", bus.RCO_TOTAL, 11);
        begin
            logic [31:0] exp_q [4] = '{32'd2, 32'd3, 32'd4, 32'd9};
            for (int i = 0; i < 4; i++) begin
                check("full_pp_drain", bus.DATA_OUT, 64'(exp_q[i]));
                tick;
            end
        end
        bus.READY = 1'b0;
        check("full_pp_empty", bus.VALID, 0);
        bus.CAP_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.RCO = 1'b1;
            tick;
            bus.RCO = 1'b0;
            tick;
        end
        check("gate_level", bus.LEVEL, 0);
        check("gate_total", bus.RCO_TOTAL, 11);
        bus.CAP_EN = 1'b1;
        bus.CLR = 1'b1;
        bus.RCO = 1'b1;
        bus.Q = 32'd5;
        tick;
        bus.CLR = 1'b0;
        bus.RCO = 1'b0;
        check("clr_total", bus.RCO_TOTAL, 1);
        check("clr_drop", bus.DROP_CNT, 0);
        check("clr_ovf", bus.OVF, 0);
        check("clr_level", bus.LEVEL, 1);
        check("clr_data", bus.DATA_OUT, 5);
        for (int i = 6; i <= 8; i++) begin
            bus.Q = 32'(i);
            bus.RCO = 1'b1;
            tick;
        end
        bus.Q = 32'hDEAD;
        for (int i = 0; i < 300; i++) tick;
        bus.RCO = 1'b0;
        check("sat_drop", bus.DROP_CNT, 255);
        check("sat_total_wrap", bus.RCO_TOTAL, 48);
        check("sat_ovf", bus.OVF, 1);
        check("sat_level", bus.LEVEL, 4);
        check("sat_head", bus.DATA_OUT, 5);
        #3 RESET = 1'b1;
        #1 RESET = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        bus.Q = 32'd100;
        bus.RCO = 1'b1;
        tick;
        bus.RCO = 1'b0;
        tick;
        tick;
        bus.Q = 32'd200;
        bus.RCO = 1'b1;
        tick;
        bus.RCO = 1'b0;
        check("ts_level", bus.LEVEL, 2);
        check("ts_data1", bus.DATA_OUT, 100);
`ifdef RCO_CAPTURE_TS_EN
        check("ts_first", bus.TS_OUT, 10);
`else
        check("ts_first", bus.TS_OUT, 0);
`endif
        bus.READY = 1'b1;
        tick;
        bus.READY = 1'b0;
        check("ts_data2", bus.DATA_OUT, 200);
`ifdef RCO_CAPTURE_TS_EN
        check("ts_second", bus.TS_OUT, 13);
`else
        check("ts_second", bus.TS_OUT, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
